// File: rtl/logic_pkg.sv
// Shared types for the logic accumulate unit: the operation codes
// and the packet FSM state encoding.
package logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation decode: r = x <op> y.
// Ports: x, y operands (WIDTH); op 3-bit code (op_e); r result (WIDTH).
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = '0;
        unique case (op_e'(op))
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            OP_PASS: r = x;
        endcase
    end

endmodule

// File: rtl/logic_accum_unit.sv
// Packet-oriented bitwise accumulator: folds beats with a logic op,
// presents the result with a saturating beat count until consumed.
// Ports: clk, rst_n (async active-low); in_valid/in_ready handshake with
// in_a, in_b, in_op, in_last; out_valid/out_ready handshake with
// out_data, out_zero, out_count, out_cnt_sat.
module logic_accum_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] y_sel;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             fire;

    assign in_ready = (state_q != ST_HOLD);
    assign fire     = in_valid && in_ready;

    // First beat combines A with B; later beats fold A into the accumulator.
    assign y_sel = (state_q == ST_IDLE) ? in_b : acc_q;

    logic_op_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x (in_a),
        .y (y_sel),
        .op(in_op),
        .r (res)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (fire) state_d = in_last ? ST_HOLD : ST_ACCUM;
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                acc_q <= res;
                if (state_q == ST_IDLE) begin
                    cnt_q <= CNT_W'(1);
                    sat_q <= 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    sat_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid   = (state_q == ST_HOLD);
    assign out_data    = acc_q;
    assign out_count   = cnt_q;
    assign out_cnt_sat = sat_q;
    // Qualified by HOLD so the flag reads 0 out of reset and mid-packet.
    assign out_zero    = out_valid && (acc_q == '0);

endmodule

// File: doc/logic_accum_unit.md
LOGIC_ACCUM_UNIT -- requirements
Module: logic_accum_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (1..64).
REQ-002 SHALL have parameter CNT_W, default 8, width of the beat counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  unit accepts a beat this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B, used on first beat of a packet only.
REQ-009 SHALL have port in_op  input  3  operation code.
REQ-010 SHALL have port in_last  input  1  beat closes the packet.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_data  output  WIDTH  accumulated result.
REQ-014 SHALL have port out_zero  output  1  out_data equals 0.
REQ-015 SHALL have port out_count  output  CNT_W  beats in the packet, saturating.
REQ-016 SHALL have port out_cnt_sat  output  1  beat counter saturated.

Function
REQ-017 SHALL decode in_op as: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (x & ~y), 111 PASS (result = x); all bitwise over WIDTH.
REQ-018 SHALL implement FSM states IDLE, ACCUM, HOLD; reset state IDLE.
REQ-019 SHALL accept a beat exactly when in_valid && in_ready; in_ready = (state != HOLD).
REQ-020 SHALL, on a beat accepted in IDLE, load acc <= in_a op in_b, count <= 1.
REQ-021 SHALL, on a beat accepted in ACCUM, load acc <= in_a op acc (x = in_a, y = acc), ignore in_b, count <= count+1 saturating at 2^CNT_W-1.
REQ-022 SHALL transition IDLE/ACCUM -> HOLD when the accepted beat has in_last=1, else IDLE -> ACCUM, ACCUM -> ACCUM.
REQ-023 SHALL assert out_valid only in HOLD; result visible the cycle after the last beat is accepted (latency 1).
REQ-024 SHALL transition HOLD -> IDLE on out_ready=1; no bypass: a beat presented in that cycle is not accepted (in_ready=0).
REQ-025 SHALL hold out_data, out_zero, out_count, out_cnt_sat stable while out_valid && !out_ready.
REQ-026 SHALL set out_cnt_sat when an accepted beat would overflow count; flag clears at next packet start.
REQ-027 SHALL derive out_zero from the registered result, no extra latency.
REQ-028 SHALL ignore in_a/in_b/in_op/in_last when no beat is accepted.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-packet, immediately force state IDLE, acc 0, count 0, out_valid 0, out_data 0, out_zero 0, out_count 0, out_cnt_sat 0; partial packets are discarded.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-031 SHALL take op codes (enum) and FSM state typedef from shared package logic_pkg.
REQ-032 SHALL place the combinational op decode in sub-module logic_op_core (params WIDTH; ports x, y, op, r).

Verification (WIDTH=8, CNT_W=8)
REQ-033 SHALL cover single beat: a=0xF0, b=0x3C, op=AND, last=1 -> next cycle out_valid=1, out_data=0x30, out_count=1, out_zero=0.
REQ-034 SHALL cover 3-beat packet: (a=0x01,b=0x02,XOR), (a=0x04,OR), (a=0x07,XOR,last) -> out_data=0x00, out_zero=1, out_count=3.
REQ-035 SHALL cover backpressure: hold out_ready=0 for 5 cycles after result -> out_data/out_count stable, in_ready=0, offered beats not accepted; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover reset mid-packet: 2 beats accepted then rst_n=0 -> all outputs 0 asynchronously; next packet (a=0xFF,b=0x0F,NAND,last) -> out_data=0xF0, out_count=1.
REQ-037 SHALL cover saturation: 300-beat packet of PASS a=0x55 -> out_count=255, out_cnt_sat=1, out_data=0x55; following 1-beat packet -> out_cnt_sat=0.
REQ-038 SHALL cover op table: a=0xCC, b=0xAA for every in_op -> 0x88, 0xEE, 0x66, 0x77, 0x11, 0x99, 0x44, 0xCC.
